// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU load/store port: one request at a time,
// programmable wait states, byte-enabled stores, misaligned/range error reporting.
module dmem_responder #(
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IW = ADDR_W - 2;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [IW-1:0]     acc_idx;
    logic [AW-1:0]     mem_idx;
    logic              acc_err;

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency accesses happen on the accept edge, before the latch fills.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_idx = acc_addr[ADDR_W-1:2];
    assign mem_idx = acc_idx[AW-1:0];
    assign acc_err = (acc_addr[1:0] != 2'b00)
                  || (64'(acc_idx) >= 64'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_we && !acc_err) ? mem[mem_idx] : 32'd0;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[mem_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        reset1 = 1'b0;
    logic        req_ready1;
    logic        rsp_valid1;
    logic [31:0] rsp_rdata1;
    logic        rsp_err1;
    logic        busy1;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset1),
        .req_valid(1'b1), .req_ready(req_ready1),
        .req_we(1'b0), .req_addr(32'h8),
        .req_wdata(32'd0), .req_be(4'hF),
        .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 30) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err);
        int lat;
        wait_ready(tag);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int n;

        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rel_ready", 32'(req_ready), 32'd1);

        // basic store/load
        txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        txn("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);

        // partial byte enables
        txn("st_part", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'd0, 1'b0);
        txn("ld_part", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22BE44, 1'b0);

        // errors and boundaries
        txn("ld_mis", 1'b0, 32'h13, 32'd0, 4'hF, 32'd0, 1'b1);
        txn("st_last", 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
        txn("st_oor", 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'd0, 1'b1);
        txn("ld_last", 1'b0, 32'hFFC, 32'd0, 4'hF, 32'hA5A5A5A5, 1'b0);
        txn("ld_keep", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22BE44, 1'b0);
        txn("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
        txn("ld_be0", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22BE44, 1'b0);

        // back-pressure on the response
        wait_ready("bp");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        held = rsp_rdata;
        check("bp_first", held, 32'hDE22BE44);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_wdata = 32'hFFFFFFFF;
            end
            step();
            req_valid = 1'b0;
            req_we    = 1'b0;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hDE22BE44);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_idle", 32'(req_ready), 32'd1);
        txn("bp_next", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22BE44, 1'b0);

        // reset while a store waits
        txn("st_prior", 1'b1, 32'h20, 32'h12345678, 4'hF, 32'd0, 1'b0);
        txn("ld_prior", 1'b0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);
        wait_ready("rw");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("rw_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rw_busy0", 32'(busy), 32'd0);
        check("rw_ready0", 32'(req_ready), 32'd0);
        check("rw_valid0", 32'(rsp_valid), 32'd0);
        check("rw_rdata0", rsp_rdata, 32'd0);
        check("rw_err0", 32'(rsp_err), 32'd0);
        step();
        reset = 1'b1;
        txn("ld_after", 1'b0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);

        // zero-latency instance streaming
        step();
        reset1 = 1'b1;
        #1;
        check("z_ready", 32'(req_ready1), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("z_busy", 32'(busy1), 32'(i % 2 == 0));
            check("z_valid", 32'(rsp_valid1), 32'(i % 2 == 0));
            check("z_rdy", 32'(req_ready1), 32'(i % 2 != 0));
            check("z_err", 32'(rsp_err1), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
